// File: rtl/dsc_mul_operand_seq_pkg.sv
// Shared types, default parameters and helpers for the multiplier operand sequencer.
`default_nettype none

package dsc_seq_pkg;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      LOAD  = 3'd1,
      CLEAR = 3'd2,
      RUN   = 3'd3,
      OUT   = 3'd4
   } seq_state_t;

   localparam int DEF_DATA_WIDTH = 5;
   localparam int DEF_NUM_INPUTS = 2;
   localparam int DEF_WXIP1      = 1;
   localparam int DEF_CNT_W      = 13;
   localparam int DEF_TIMEOUT    = 4096;

   // Index width that never collapses to zero bits for a single operand.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dsc_mul_operand_seq_if.sv
// Operand stream, multiplier control and result stream bundle for the operand sequencer.
`default_nettype none

interface dsc_mul_operand_seq_if
   import dsc_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_INPUTS = DEF_NUM_INPUTS,
   parameter int WXIP1      = DEF_WXIP1,
   parameter int CNT_W      = DEF_CNT_W
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;

   logic                  mul_clr;
   logic                  mul_en;
   logic [DATA_WIDTH-1:0] mul_data [NUM_INPUTS];
   logic [WXIP1-1:0]      mul_result;
   logic                  mul_done;

   logic                  out_valid;
   logic                  out_ready;
   logic [WXIP1-1:0]      out_result;
   logic [CNT_W-1:0]      out_cycles;
   logic                  out_err;

   // Sequencer side.
   modport slave (
      input  in_valid, in_data, mul_result, mul_done, out_ready,
      output in_ready, mul_clr, mul_en, mul_data,
             out_valid, out_result, out_cycles, out_err
   );

   // Producer / multiplier / consumer side.
   modport master (
      output in_valid, in_data, mul_result, mul_done, out_ready,
      input  in_ready, mul_clr, mul_en, mul_data,
             out_valid, out_result, out_cycles, out_err
   );

endinterface

`default_nettype wire

// File: rtl/dsc_mul_operand_seq_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
`default_nettype none

module dsc_sat_counter #(
   parameter int WIDTH = 13
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/dsc_mul_operand_seq.sv
// Collects operand beats, runs the multiplier under a watchdog and returns result plus cycle count.
`default_nettype none

module dsc_mul_operand_seq
   import dsc_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_INPUTS = DEF_NUM_INPUTS,
   parameter int WXIP1      = DEF_WXIP1,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   dsc_mul_operand_seq_if.slave  bus_io
);

   localparam int                 IDX_W     = clog2_min1(NUM_INPUTS);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_INPUTS - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);

   seq_state_t            state_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] op_q [NUM_INPUTS];

   logic                  in_ready_q;
   logic                  mul_clr_q;
   logic                  mul_en_q;
   logic                  out_valid_q;
   logic                  out_err_q;
   logic [WXIP1-1:0]      out_result_q;
   logic [CNT_W-1:0]      out_cycles_q;

   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_inc_d;
   logic                  cnt_clr;
   logic                  cnt_en;

   assign cnt_clr   = (state_q == CLEAR);
   assign cnt_en    = (state_q == RUN);
   // cnt_q+1 is the number of RUN cycles including the current one.
   assign cnt_inc_d = cnt_q + CNT_W'(1);

   dsc_sat_counter #(
      .WIDTH (CNT_W)
   ) u_run_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt_q)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= INIT;
         idx_q        <= '0;
         in_ready_q   <= 1'b0;
         mul_clr_q    <= 1'b0;
         mul_en_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_err_q    <= 1'b0;
         out_result_q <= '0;
         out_cycles_q <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            op_q[i] <= '0;
         end
      end else begin
         case (state_q)
            INIT: begin
               in_ready_q <= 1'b1;
               state_q    <= LOAD;
            end
            LOAD: begin
               if (bus_io.in_valid && in_ready_q) begin
                  op_q[idx_q] <= bus_io.in_data;
                  if (idx_q == LAST_IDX) begin
                     idx_q      <= '0;
                     in_ready_q <= 1'b0;
                     mul_clr_q  <= 1'b1;
                     state_q    <= CLEAR;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            CLEAR: begin
               mul_clr_q <= 1'b0;
               mul_en_q  <= 1'b1;
               state_q   <= RUN;
            end
            RUN: begin
               // A done arriving on the watchdog's last cycle still counts as success.
               if (bus_io.mul_done) begin
                  out_result_q <= bus_io.mul_result;
                  out_cycles_q <= cnt_inc_d;
                  out_err_q    <= 1'b0;
                  mul_en_q     <= 1'b0;
                  out_valid_q  <= 1'b1;
                  state_q      <= OUT;
               end else if (cnt_inc_d == TIMEOUT_C) begin
                  out_result_q <= '0;
                  out_cycles_q <= TIMEOUT_C;
                  out_err_q    <= 1'b1;
                  mul_en_q     <= 1'b0;
                  out_valid_q  <= 1'b1;
                  state_q      <= OUT;
               end
            end
            OUT: begin
               if (bus_io.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  idx_q       <= '0;
                  state_q     <= LOAD;
               end
            end
            default: begin
               state_q <= INIT;
            end
         endcase
      end
   end

   assign bus_io.in_ready   = in_ready_q;
   assign bus_io.mul_clr    = mul_clr_q;
   assign bus_io.mul_en     = mul_en_q;
   assign bus_io.mul_data   = op_q;
   assign bus_io.out_valid  = out_valid_q;
   assign bus_io.out_result = out_result_q;
   assign bus_io.out_cycles = out_cycles_q;
   assign bus_io.out_err    = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dsc_mul_operand_seq.sv
// Directed bench for the operand sequencer with a cycle-counting multiplier stub.
`default_nettype none

module tb_dsc_mul_operand_seq;

   localparam int DW = 5;
   localparam int NI = 2;
   localparam int WX = 1;
   localparam int CW = 13;
   localparam int TO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dsc_mul_operand_seq_if #(
      .DATA_WIDTH (DW),
      .NUM_INPUTS (NI),
      .WXIP1      (WX),
      .CNT_W      (CW)
   ) bus ();

   dsc_mul_operand_seq #(
      .DATA_WIDTH (DW),
      .NUM_INPUTS (NI),
      .WXIP1      (WX),
      .CNT_W      (CW),
      .TIMEOUT    (TO)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   int   done_at    = 0;
   logic stray      = 1'b0;
   int   stub_cnt   = 0;
   int   clr_pulses = 0;
   int   n_pass     = 0;
   int   n_total    = 0;

   // Multiplier stub: raises done on RUN cycle number done_at (0 = never).
   always @(posedge clk) stub_cnt <= bus.mul_en ? stub_cnt + 1 : 0;
   assign bus.mul_done = stray | (bus.mul_en && (done_at != 0) && (stub_cnt + 1 == done_at));

   always @(negedge clk) if (bus.mul_clr) clr_pulses <= clr_pulses + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Called just after a rising edge while in LOAD; leaves the DUT in CLEAR.
   task automatic send2(input logic [DW-1:0] a, input logic [DW-1:0] b);
      bus.in_valid = 1'b1;
      bus.in_data  = a;
      @(posedge clk); #1;
      bus.in_data  = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int en_cyc);
      en_cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) return;
         if (bus.mul_en) en_cyc++;
      end
      chk("out_valid_wait", 32'd0, 32'd1);
   endtask

   task automatic handshake();
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   int en_cyc;
   int clr_base;
   int snap_cycles;

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b0;
      bus.mul_result = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",   bus.in_ready,    0);
      chk("rst_mul_clr",    bus.mul_clr,     0);
      chk("rst_mul_en",     bus.mul_en,      0);
      chk("rst_out_valid",  bus.out_valid,   0);
      chk("rst_out_err",    bus.out_err,     0);
      chk("rst_out_result", bus.out_result,  0);
      chk("rst_out_cycles", bus.out_cycles,  0);
      chk("rst_mul_data0",  bus.mul_data[0], 0);
      chk("rst_mul_data1",  bus.mul_data[1], 0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("init_in_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("load_in_ready", bus.in_ready, 1);

      // Nominal: 13, 7, done on RUN cycle 8 with result 1.
      @(posedge clk); #1;
      done_at = 8; bus.mul_result = 1'b1;
      clr_base = clr_pulses;
      send2(5'd13, 5'd7);
      @(negedge clk);
      chk("nom_clear_clr",  bus.mul_clr,  1);
      chk("nom_clear_en",   bus.mul_en,   0);
      chk("nom_clear_rdy",  bus.in_ready, 0);
      wait_out(en_cyc);
      chk("nom_run_cycles", en_cyc,          8);
      chk("nom_clr_once",   clr_pulses - clr_base, 1);
      chk("nom_data0",      bus.mul_data[0], 13);
      chk("nom_data1",      bus.mul_data[1], 7);
      chk("nom_result",     bus.out_result,  1);
      chk("nom_cycles",     bus.out_cycles,  8);
      chk("nom_err",        bus.out_err,     0);
      chk("nom_en_drop",    bus.mul_en,      0);

      // Backpressure with a beat offered during OUT.
      bus.in_valid = 1'b1; bus.in_data = 5'd9;
      done_at = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid",  bus.out_valid,   1);
         chk("bp_rdy",    bus.in_ready,    0);
         chk("bp_cycles", bus.out_cycles,  8);
         chk("bp_result", bus.out_result,  1);
         chk("bp_data0",  bus.mul_data[0], 13);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("hs_in_ready",  bus.in_ready,    1);
      chk("hs_out_valid", bus.out_valid,   0);
      chk("hs_data0_old", bus.mul_data[0], 13);
      @(posedge clk); #1;
      chk("bp_beat_taken", bus.mul_data[0], 9);
      bus.in_data = 5'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;

      // Timeout: the stub never answers.
      wait_out(en_cyc);
      chk("to_run_cycles", en_cyc,          16);
      chk("to_err",        bus.out_err,     1);
      chk("to_result",     bus.out_result,  0);
      chk("to_cycles",     bus.out_cycles,  16);
      chk("to_en_drop",    bus.mul_en,      0);
      chk("to_data1",      bus.mul_data[1], 3);
      handshake();

      // Done coincides with the last watchdog cycle.
      done_at = 16; bus.mul_result = 1'b1;
      send2(5'd2, 5'd4);
      wait_out(en_cyc);
      chk("co_err",    bus.out_err,    0);
      chk("co_cycles", bus.out_cycles, 16);
      chk("co_result", bus.out_result, 1);
      handshake();

      // Stray done in LOAD is ignored.
      done_at = 0;
      stray = 1'b1;
      repeat (2) @(negedge clk);
      chk("stray_valid", bus.out_valid, 0);
      chk("stray_rdy",   bus.in_ready,  1);
      chk("stray_en",    bus.mul_en,    0);
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = 5'd21;
      @(posedge clk); #1;
      stray = 1'b0;
      chk("stray_first_clr", bus.mul_clr,     0);
      chk("stray_first_d0",  bus.mul_data[0], 21);
      bus.in_data = 5'd10;
      done_at = 5;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_out(en_cyc);
      chk("stray_cycles", bus.out_cycles,  5);
      chk("stray_d1",     bus.mul_data[1], 10);
      handshake();

      // Asynchronous reset in the middle of RUN.
      done_at = 8;
      send2(5'd11, 5'd12);
      repeat (4) @(negedge clk);
      chk("mid_in_run", bus.mul_en, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_en",     bus.mul_en,      0);
      chk("ar_valid",  bus.out_valid,   0);
      chk("ar_rdy",    bus.in_ready,    0);
      chk("ar_cycles", bus.out_cycles,  0);
      chk("ar_result", bus.out_result,  0);
      chk("ar_data0",  bus.mul_data[0], 0);
      @(negedge clk);
      chk("ar_hold_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_init_rdy", bus.in_ready, 0);
      @(negedge clk);
      chk("ar_load_rdy", bus.in_ready, 1);
      @(posedge clk); #1;
      done_at = 3; bus.mul_result = 1'b0;
      snap_cycles = 0;
      send2(5'd5, 5'd6);
      wait_out(en_cyc);
      chk("post_cycles", bus.out_cycles,  3);
      chk("post_err",    bus.out_err,     0);
      chk("post_result", bus.out_result,  snap_cycles);
      chk("post_data0",  bus.mul_data[0], 5);
      chk("post_data1",  bus.mul_data[1], 6);
      handshake();
      @(negedge clk);
      chk("post_hs_valid", bus.out_valid, 0);
      chk("post_hs_rdy",   bus.in_ready,  1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dsc_mul_operand_seq.md
# dsc_mul_operand_seq

Operand sequencer and result capture stage wrapped around the `ms_es_ordered_cas_by4_mul` core. It accepts NUM_INPUTS binary operands one per beat over a valid/ready stream and presents them in parallel to the multiplier. It clears and enables the multiplier, waits for its `done`, and returns the result plus a run-cycle count over a second valid/ready stream. A watchdog bounds every run.

## Interface
- DATA_WIDTH, 5, operand width in bits
- NUM_INPUTS, 2, operands per operation
- WXIP1, 1, multiplier result width
- CNT_W, 13, width of cycle counter and `out_cycles`
- TIMEOUT, 4096, maximum RUN cycles before abort; must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_W − 1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  sequencer accepts a beat
- in_data  in  DATA_WIDTH  operand value
- mul_clr  out  1  one-cycle synchronous clear to the multiplier (active-high)
- mul_en  out  1  multiplier enable
- mul_data  out  DATA_WIDTH × NUM_INPUTS (unpacked)  operand array; index 0 is the first beat
- mul_result  in  WXIP1  multiplier result
- mul_done  in  1  multiplier finished
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WXIP1  captured result (0 on timeout)
- out_cycles  out  CNT_W  RUN cycles consumed, including the cycle `mul_done` was seen
- out_err  out  1  run hit TIMEOUT without `mul_done`

## Operation
- FSM states: INIT, LOAD, CLEAR, RUN, OUT. Reset state is INIT.
- INIT goes to LOAD unconditionally.
- LOAD:
  - `in_ready`=1.
  - On `in_valid && in_ready`, `op[idx] <= in_data` and `idx++`.
  - Acceptance of beat NUM_INPUTS−1 moves to CLEAR.
- CLEAR: `mul_clr`=1 for exactly one cycle and `mul_en`=0. Counter is cleared to 0. Then RUN.
- RUN:
  - `mul_en`=1 and the counter increments every cycle.
  - If `mul_done`=1: capture `mul_result` and counter+1 into the output registers, set `out_err`=0, go to OUT.
  - Else if counter+1 == TIMEOUT: set `out_result`=0, `out_cycles`=TIMEOUT, `out_err`=1, go to OUT.
  - If `mul_done` and timeout coincide, `mul_done` wins.
- OUT:
  - `out_valid`=1. Output registers are stable until the handshake completes.
  - On `out_ready`: `idx`=0, go to LOAD.
- `mul_data` is driven from the operand registers at all times. It is stable from CLEAR through OUT.
- `in_ready`=0 outside LOAD; beats offered then are not consumed.
- `mul_done` outside RUN is ignored.
- Reset values:
  - `in_ready`, `mul_clr`, `mul_en`, `out_valid`, `out_err` = 0.
  - `out_result`, `out_cycles`, `mul_data`, `idx`, counter = 0.
- Reset mid-operation aborts asynchronously to INIT with all reset values. No partial result is emitted.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational in→out path.
- First cycle after `rst` release: INIT (`in_ready`=0). `in_ready`=1 from the second cycle.
- Final beat accepted at edge t:
  - CLEAR (`mul_clr`=1) during cycle t+1.
  - `mul_en`=1 from cycle t+2.
- `mul_done` sampled at edge d:
  - `mul_en`=0 and `out_valid`=1 from cycle d+1.
  - `out_cycles` = (d − (t+2)) + 1.
- `out_ready` sampled high with `out_valid` at edge h: `in_ready`=1 in cycle h+1.
- Minimum operation: NUM_INPUTS beats + 1 CLEAR + 1 RUN + 1 OUT cycle.
- Back-to-back `in_valid` achieves one beat per cycle in LOAD.

## Structure
- Package `dsc_seq_pkg`:
  - State enum typedef `seq_state_t` {INIT, LOAD, CLEAR, RUN, OUT}.
  - Default parameter constants.
  - Function `clog2_min1` for `idx` width (max(1, $clog2(NUM_INPUTS))).
- One sub-module, `dsc_sat_counter`: CNT_W-bit counter with sync clear and enable, saturating at all-ones. Instantiated for the RUN counter.
- Operand store is a register array inside the top module. No FIFO.

## Test plan
- Nominal, DATA_WIDTH=5, NUM_INPUTS=2:
  - Stimulus: beats 13, 7 back-to-back; stub asserts `mul_done` on the 8th RUN cycle with `mul_result`=1.
  - Required: `mul_clr` pulses once; `mul_data`={13,7}; `out_valid`=1 with `out_result`=1, `out_cycles`=8, `out_err`=0.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Required: outputs stable; `in_ready` stays 0; a beat offered meanwhile is not consumed and is accepted first after the handshake.
- Timeout, TIMEOUT=16:
  - Stimulus: stub never asserts `mul_done`.
  - Required: `out_valid` after 16 RUN cycles; `out_err`=1, `out_result`=0, `out_cycles`=16; `mul_en` drops.
- Coincidence:
  - Stimulus: `mul_done` on RUN cycle 16 with TIMEOUT=16.
  - Required: `out_err`=0, `out_cycles`=16, result captured.
- Reset mid-RUN:
  - Stimulus: assert `rst`=0 asynchronously mid-cycle.
  - Required: outputs go to reset values immediately, with no `out_valid`; after release, one INIT cycle, then a new operation completes normally.
- Stray `mul_done`:
  - Stimulus: pulse `mul_done` during LOAD.
  - Required: no state change, no `out_valid`.
